pipelined_slice_adder: RTL and testbench



---
 rtl/pipelined_slice_adder.sv | 123 ++++++++++++
 tb/tb_pipelined_slice_adder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipelined_slice_adder.sv
// Pipelined add/subtract unit. Each stage resolves one SLICE-bit ripple slice,
// with the slice carry registered between stages and a valid/ready handshake.
module pipelined_slice_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int STAGES = WIDTH / SLICE;

  logic w_adv;

  // Per-stage inputs: index 0 is the conditioned operand set, index k+1 is
  // what stage k has registered for the next stage.
  logic [WIDTH-1:0] w_a [STAGES];
  logic [WIDTH-1:0] w_b [STAGES];
  logic [WIDTH-1:0] w_s [STAGES];
  logic             w_c [STAGES];
  logic             w_v [STAGES];

  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;

  assign w_a[0] = A;
  assign w_b[0] = sub ? ~B : B;
  assign w_c[0] = cin ^ sub;
  assign w_s[0] = '0;
  assign w_v[0] = in_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SLICE-1:0] w_sa;
    logic [SLICE-1:0] w_sb;
    logic [SLICE-1:0] w_ss;
    logic             w_co;
    logic [WIDTH-1:0] w_snext;

    assign w_sa = w_a[k][k*SLICE +: SLICE];
    assign w_sb = w_b[k][k*SLICE +: SLICE];
    assign {w_co, w_ss} = {1'b0, w_sa} + {1'b0, w_sb} + {{SLICE{1'b0}}, w_c[k]};

    always_comb begin
      w_snext = w_s[k];
      w_snext[k*SLICE +: SLICE] = w_ss;
    end

    if (k < STAGES - 1) begin : g_mid
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;
      logic [WIDTH-1:0] r_s;
      logic             r_c;
      logic             r_v;

      // Data registers load only for valid entries; bubbles just move the valid bit.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
          r_s <= '0;
          r_c <= 1'b0;
          r_v <= 1'b0;
        end else if (w_adv) begin
          r_v <= w_v[k];
          if (w_v[k]) begin
            r_a <= w_a[k];
            r_b <= w_b[k];
            r_s <= w_snext;
            r_c <= w_co;
          end
        end
      end

      assign w_a[k+1] = r_a;
      assign w_b[k+1] = r_b;
      assign w_s[k+1] = r_s;
      assign w_c[k+1] = r_c;
      assign w_v[k+1] = r_v;
    end else begin : g_last
      logic             w_cmsb;
      logic [WIDTH-1:0] r_sum;
      logic             r_cout;
      logic             r_ovf;
      logic             r_v;

      // Carry into the MSB recovered from the MSB sum bit itself.
      assign w_cmsb = w_sa[SLICE-1] ^ w_sb[SLICE-1] ^ w_ss[SLICE-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_sum  <= '0;
          r_cout <= 1'b0;
          r_ovf  <= 1'b0;
          r_v    <= 1'b0;
        end else if (w_adv) begin
          r_v <= w_v[k];
          if (w_v[k]) begin
            r_sum  <= w_snext;
            r_cout <= w_co;
            r_ovf  <= w_cmsb ^ w_co;
          end
        end
      end

      assign Sum       = r_sum;
      assign carryout  = r_cout;
      assign overflow  = r_ovf;
      assign out_valid = r_v;
    end
  end

endmodule

// File: tb/tb_pipelined_slice_adder.sv
// Directed and randomized checks of pipelined_slice_adder against an
// arithmetic reference (A + Bi + c0) across several WIDTH/SLICE choices.
module tb_pipelined_slice_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit rnd_go = 1'b0;
  int rnd_done = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Directed instance, default parameters
  logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready;
  logic [15:0] d_a, d_b, d_sum;
  logic        d_cin, d_sub, d_cout, d_ovf;

  pipelined_slice_adder #(.WIDTH(16), .SLICE(4)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(d_in_valid), .in_ready(d_in_ready),
    .A(d_a), .B(d_b), .cin(d_cin), .sub(d_sub),
    .out_valid(d_out_valid), .out_ready(d_out_ready),
    .Sum(d_sum), .carryout(d_cout), .overflow(d_ovf)
  );

  task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic s, input logic [15:0] es,
                         input logic ec, input logic eo);
    @(negedge clk);
    d_in_valid = 1'b1; d_a = a; d_b = b; d_cin = c; d_sub = s; d_out_ready = 1'b1;
    @(negedge clk);
    d_in_valid = 1'b0;
    check({tag, "_early1"}, d_out_valid, 0);
    @(negedge clk);
    check({tag, "_early2"}, d_out_valid, 0);
    @(negedge clk);
    check({tag, "_early3"}, d_out_valid, 0);
    @(negedge clk);
    check({tag, "_valid"}, d_out_valid, 1);
    check({tag, "_sum"}, d_sum, es);
    check({tag, "_cout"}, d_cout, ec);
    check({tag, "_ovf"}, d_ovf, eo);
  endtask

  initial begin
    int issued, recv, stalls;
    logic stalling;
    d_in_valid = 0; d_a = 0; d_b = 0; d_cin = 0; d_sub = 0; d_out_ready = 1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_valid", d_out_valid, 0);
    check("rst_sum", d_sum, 0);
    check("rst_cout", d_cout, 0);
    check("rst_ovf", d_ovf, 0);
    check("rst_ready", d_in_ready, 1);

    run_one("carry_chain", 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
    run_one("ovf_add",     16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
    run_one("ovf_sub",     16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1);
    run_one("borrow",      16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0);
    run_one("borrow_cin",  16'h0005, 16'h0007, 1, 1, 16'hFFFD, 0, 0);

    // Backpressure: six back-to-back adds, three stall cycles at first result
    issued = 0; recv = 0; stalls = 0;
    for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
      @(negedge clk);
      d_in_valid = (issued < 6);
      d_a = 16'(issued); d_b = 16'h1000; d_cin = 0; d_sub = 0;
      stalling = d_out_valid && (stalls < 3);
      d_out_ready = !stalling;
      #1;
      check("bp_ready", d_in_ready, !stalling);
      if (stalling) begin
        check("bp_hold", d_sum, 16'h1000);
        stalls++;
      end
      if (d_in_valid && d_in_ready) issued++;
      if (d_out_valid && d_out_ready) begin
        check("bp_order", d_sum, 16'h1000 + 16'(recv));
        recv++;
      end
    end
    check("bp_count", recv, 6);
    check("bp_stalls", stalls, 3);
    @(negedge clk);
    d_in_valid = 0; d_out_ready = 1;
    #1;
    check("bp_extra", d_out_valid, 0);

    // Reset with three transactions in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d_in_valid = 1; d_a = 16'h0100 + 16'(i); d_b = 16'h0000; d_cin = 0; d_sub = 0;
    end
    @(negedge clk);
    d_in_valid = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_valid", d_out_valid, 0);
    check("midrst_sum", d_sum, 0);
    run_one("after_rst", 16'h0002, 16'h0003, 0, 0, 16'h0005, 0, 0);

    rnd_go = 1'b1;
    for (int cyc = 0; cyc < 80000 && rnd_done < 4; cyc++) @(posedge clk);
    check("rnd_finished", rnd_done, 4);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Randomized sweep: g0 16/4, g1 8/2, g2 8/8, g3 32/4
  localparam int N_TXN = 10000;

  for (genvar g = 0; g < 4; g++) begin : g_rnd
    localparam int W = (g == 0) ? 16 : (g == 3) ? 32 : 8;
    localparam int S = (g == 1) ? 2 : (g == 2) ? 8 : 4;

    logic         iv, ir, ov, ordy, ci, sb, co, of;
    logic [W-1:0] a, b, s;
    logic [W+1:0] q [$];

    pipelined_slice_adder #(.WIDTH(W), .SLICE(S)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(iv), .in_ready(ir),
      .A(a), .B(b), .cin(ci), .sub(sb),
      .out_valid(ov), .out_ready(ordy),
      .Sum(s), .carryout(co), .overflow(of)
    );

    initial begin
      int acc, cyc;
      logic [W:0]   full;
      logic [W-1:0] bi;
      logic [W+1:0] e, f;
      string tag;
      tag = $sformatf("rnd_w%0d_s%0d", W, S);
      iv = 0; ordy = 1; a = 0; b = 0; ci = 0; sb = 0;
      wait (rnd_go);
      acc = 0; cyc = 0;
      while ((acc < N_TXN || q.size() != 0) && cyc < 60000) begin
        @(negedge clk);
        iv   = (acc < N_TXN) && ($urandom_range(3) != 0);
        a    = W'($urandom());
        b    = W'($urandom());
        ci   = 1'($urandom_range(1));
        sb   = 1'($urandom_range(1));
        ordy = ($urandom_range(3) != 0);
        #1;
        if (ov && ordy) begin
          if (q.size() == 0) check({tag, "_dup"}, 1, 0);
          else begin
            f = q.pop_front();
            check(tag, {of, co, s}, f);
          end
        end
        if (iv && ir) begin
          bi   = sb ? ~b : b;
          full = {1'b0, a} + {1'b0, bi} + (W+1)'(ci ^ sb);
          e[W-1:0] = full[W-1:0];
          e[W]     = full[W];
          e[W+1]   = (a[W-1] == bi[W-1]) && (full[W-1] != a[W-1]);
          q.push_back(e);
          acc++;
        end
        cyc++;
      end
      check({tag, "_accepted"}, acc, N_TXN);
      check({tag, "_drained"}, q.size(), 0);
      iv = 0;
      rnd_done++;
    end
  end

endmodule
